// File: rtl/mem_stage.sv
// Data-memory pipeline stage: async-read word array with byte/half lanes, plus MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN flags misaligned half/word accesses and suppresses their side effects.
module mem_stage #(
   parameter int DEPTH = 256
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic        RegWriteIn,
   input  logic        MemToReg,
   input  logic [4:0]  RegDestIn,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] MEM_ReadData,
   output logic        WB_RegWrite,
   output logic [4:0]  WB_RegDest,
   output logic [31:0] WB_Data,
   output logic        AlignErr
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wordIdx;
   logic [1:0]    byteSel;
   logic [31:0]   rdWord;
   logic [31:0]   wrWord;
   logic [7:0]    rdByte;
   logic [15:0]   rdHalf;
   logic          alignErr;
   logic          storeEn;

   assign wordIdx = ALUResult[AW+1:2];
   assign byteSel = ALUResult[1:0];
   assign rdWord  = mem[wordIdx];
   assign rdByte  = rdWord[{byteSel, 3'b000} +: 8];
   assign rdHalf  = ALUResult[1] ? rdWord[31:16] : rdWord[15:0];

`ifdef MEM_ALIGN_CHECK_EN
   // Only real memory accesses can be misaligned; plain ALU results pass untouched.
   always_comb begin
      alignErr = 1'b0;
      if (MemRead || MemWrite) begin
         case (MemSize)
            2'b01:   alignErr = ALUResult[0];
            2'b10:   alignErr = 1'b0;
            default: alignErr = (byteSel != 2'b00);
         endcase
      end
   end
`else
   assign alignErr = 1'b0;
`endif

   assign AlignErr = alignErr;

   always_comb begin
      MEM_ReadData = 32'b0;
      if (MemRead && !alignErr) begin
         case (MemSize)
            2'b10:   MEM_ReadData = {{24{MemSigned & rdByte[7]}}, rdByte};
            2'b01:   MEM_ReadData = {{16{MemSigned & rdHalf[15]}}, rdHalf};
            default: MEM_ReadData = rdWord;
         endcase
      end
   end

   // Read-modify-write of the addressed word so only the selected lanes change.
   always_comb begin
      wrWord = rdWord;
      case (MemSize)
         2'b10: wrWord[{byteSel, 3'b000} +: 8] = WriteData[7:0];
         2'b01: begin
            if (ALUResult[1]) wrWord[31:16] = WriteData[15:0];
            else              wrWord[15:0]  = WriteData[15:0];
         end
         default: wrWord = WriteData;
      endcase
   end

   assign storeEn = MemWrite && !Stall && !Reset && !alignErr;

   always_ff @(posedge Clock) begin
      if (storeEn) mem[wordIdx] <= wrWord;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         WB_RegWrite <= 1'b0;
         WB_RegDest  <= 5'd0;
         WB_Data     <= 32'b0;
      end else if (!Stall) begin
         WB_RegWrite <= RegWriteIn && (RegDestIn != 5'd0) && !alignErr;
         WB_RegDest  <= RegDestIn;
         WB_Data     <= MemToReg ? MEM_ReadData : ALUResult;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage, plus hand sequences for stall and reset.
module tb_mem_stage;

   logic        Clock = 1'b0;
   logic        Reset, Stall, MemWrite, MemRead, MemSigned, RegWriteIn, MemToReg;
   logic [1:0]  MemSize;
   logic [4:0]  RegDestIn;
   logic [31:0] ALUResult, WriteData;
   logic [31:0] MEM_ReadData, WB_Data;
   logic        WB_RegWrite, AlignErr;
   logic [4:0]  WB_RegDest;

   int errors = 0;
   int checks = 0;

   mem_stage #(.DEPTH(256)) dut (
      .Clock(Clock), .Reset(Reset), .Stall(Stall), .MemWrite(MemWrite), .MemRead(MemRead),
      .MemSize(MemSize), .MemSigned(MemSigned), .RegWriteIn(RegWriteIn), .MemToReg(MemToReg),
      .RegDestIn(RegDestIn), .ALUResult(ALUResult), .WriteData(WriteData),
      .MEM_ReadData(MEM_ReadData), .WB_RegWrite(WB_RegWrite), .WB_RegDest(WB_RegDest),
      .WB_Data(WB_Data), .AlignErr(AlignErr)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      string       name;
      logic        wr, rd, sgn, rw, m2r;
      logic [1:0]  size;
      logic [4:0]  dest;
      logic [31:0] alu, wdata;
      logic [31:0] expRd;
      logic        expAe;
      logic        expRw;
      logic [4:0]  expDest;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs[$];
   logic        lastRw;
   logic [4:0]  lastDest;
   logic [31:0] lastData;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic addv(input string name, input logic wr, input logic rd, input logic [1:0] size,
                       input logic sgn, input logic rw, input logic m2r, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] wdata, input logic [31:0] expRd,
                       input logic expAe, input logic expRw, input logic [31:0] expData);
      vec_t v;
      v.name = name; v.wr = wr; v.rd = rd; v.size = size; v.sgn = sgn; v.rw = rw; v.m2r = m2r;
      v.dest = dest; v.alu = alu; v.wdata = wdata; v.expRd = expRd; v.expAe = expAe;
      v.expRw = expRw; v.expDest = dest; v.expData = expData;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic wr, input logic rd, input logic [1:0] size, input logic sgn,
                        input logic rw, input logic m2r, input logic [4:0] dest,
                        input logic [31:0] alu, input logic [31:0] wdata);
      MemWrite = wr; MemRead = rd; MemSize = size; MemSigned = sgn; RegWriteIn = rw;
      MemToReg = m2r; RegDestIn = dest; ALUResult = alu; WriteData = wdata;
   endtask

   initial begin
      //   name          wr rd size  sg rw m2r dest alu           wdata         expRd         ae rw expData
      addv("sw_dead",    1, 0, 2'b00, 0, 0, 0, 0,  32'h10,       32'hDEADBEEF, 32'h0,        0, 0, 32'h10);
      addv("lw_dead",    0, 1, 2'b00, 0, 1, 1, 5,  32'h10,       32'h0,        32'hDEADBEEF, 0, 1, 32'hDEADBEEF);
      addv("sw_clr10",   1, 0, 2'b00, 0, 0, 0, 0,  32'h10,       32'h0,        32'h0,        0, 0, 32'h10);
      addv("sb_80",      1, 0, 2'b10, 0, 0, 0, 0,  32'h13,       32'h12345680, 32'h0,        0, 0, 32'h13);
      addv("lb_s",       0, 1, 2'b10, 1, 1, 1, 6,  32'h13,       32'h0,        32'hFFFFFF80, 0, 1, 32'hFFFFFF80);
      addv("lbu",        0, 1, 2'b10, 0, 1, 1, 7,  32'h13,       32'h0,        32'h00000080, 0, 1, 32'h00000080);
      addv("lw_80",      0, 1, 2'b00, 0, 1, 1, 8,  32'h10,       32'h0,        32'h80000000, 0, 1, 32'h80000000);
      addv("sw_clr20",   1, 0, 2'b00, 0, 0, 0, 0,  32'h20,       32'h0,        32'h0,        0, 0, 32'h20);
      addv("sh_1234",    1, 0, 2'b01, 0, 0, 0, 0,  32'h22,       32'hABCD1234, 32'h0,        0, 0, 32'h22);
      addv("lh_22",      0, 1, 2'b01, 1, 1, 1, 9,  32'h22,       32'h0,        32'h00001234, 0, 1, 32'h00001234);
      addv("lh_20",      0, 1, 2'b01, 1, 1, 1, 10, 32'h20,       32'h0,        32'h0,        0, 1, 32'h0);
      addv("sw_alias",   1, 0, 2'b00, 0, 0, 0, 0,  32'h400,      32'h77,       32'h0,        0, 0, 32'h400);
      addv("lw_alias",   0, 1, 2'b00, 0, 1, 1, 11, 32'h0,        32'h0,        32'h77,       0, 1, 32'h77);
      addv("dest0",      0, 0, 2'b00, 0, 1, 0, 0,  32'h99,       32'h0,        32'h0,        0, 0, 32'h99);
      addv("rd_wr_same", 1, 1, 2'b00, 0, 1, 1, 12, 32'h10,       32'hCAFEF00D, 32'h80000000, 0, 1, 32'h80000000);
      addv("lw_cafe",    0, 1, 2'b00, 0, 1, 1, 13, 32'h10,       32'h0,        32'hCAFEF00D, 0, 1, 32'hCAFEF00D);
`ifdef MEM_ALIGN_CHECK_EN
      addv("lw_mis12",   0, 1, 2'b00, 0, 1, 1, 14, 32'h12,       32'h0,        32'h0,        1, 0, 32'h0);
`else
      addv("lw_mis12",   0, 1, 2'b00, 0, 1, 1, 14, 32'h12,       32'h0,        32'hCAFEF00D, 0, 1, 32'hCAFEF00D);
`endif
      addv("lhu_12",     0, 1, 2'b01, 0, 1, 1, 15, 32'h12,       32'h0,        32'h0000CAFE, 0, 1, 32'h0000CAFE);
      addv("lh_12",      0, 1, 2'b01, 1, 1, 1, 16, 32'h12,       32'h0,        32'hFFFFCAFE, 0, 1, 32'hFFFFCAFE);
      addv("lbu_11",     0, 1, 2'b10, 0, 1, 1, 17, 32'h11,       32'h0,        32'h000000F0, 0, 1, 32'h000000F0);
      addv("size11_lw",  0, 1, 2'b11, 0, 1, 1, 18, 32'h10,       32'h0,        32'hCAFEF00D, 0, 1, 32'hCAFEF00D);

      Reset = 1'b1; Stall = 1'b0;
      drive(0, 0, 2'b00, 0, 1, 0, 5'd3, 32'h1234, 32'h0);
      @(posedge Clock); @(posedge Clock); #1;
      check("rst_rw",   {31'b0, WB_RegWrite}, 32'h0);
      check("rst_dest", {27'b0, WB_RegDest},  32'h0);
      check("rst_data", WB_Data,              32'h0);

      @(negedge Clock);
      Reset = 1'b0;
      foreach (vecs[i]) begin
         drive(vecs[i].wr, vecs[i].rd, vecs[i].size, vecs[i].sgn, vecs[i].rw, vecs[i].m2r,
               vecs[i].dest, vecs[i].alu, vecs[i].wdata);
         #1;
         check({vecs[i].name, ".rdata"}, MEM_ReadData, vecs[i].expRd);
         check({vecs[i].name, ".alignerr"}, {31'b0, AlignErr}, {31'b0, vecs[i].expAe});
         @(posedge Clock); #1;
         check({vecs[i].name, ".wb_rw"},   {31'b0, WB_RegWrite}, {31'b0, vecs[i].expRw});
         check({vecs[i].name, ".wb_dest"}, {27'b0, WB_RegDest},  {27'b0, vecs[i].expDest});
         check({vecs[i].name, ".wb_data"}, WB_Data,              vecs[i].expData);
         lastRw = vecs[i].expRw; lastDest = vecs[i].expDest; lastData = vecs[i].expData;
         @(negedge Clock);
      end

      // Stalled half store must not write, and MEM/WB holds for two cycles.
      Stall = 1'b1;
      drive(1, 0, 2'b01, 0, 1, 0, 5'd3, 32'h20, 32'h00005555);
      @(posedge Clock); @(posedge Clock); #1;
      check("stall.wb_rw",   {31'b0, WB_RegWrite}, {31'b0, lastRw});
      check("stall.wb_dest", {27'b0, WB_RegDest},  {27'b0, lastDest});
      check("stall.wb_data", WB_Data,              lastData);
      @(negedge Clock);
      Stall = 1'b0;
      drive(0, 1, 2'b00, 0, 1, 1, 5'd4, 32'h20, 32'h0);
      #1;
      check("stall.mem20", MEM_ReadData, 32'h12340000);
      @(posedge Clock); #1;
      check("stall.after_data", WB_Data, 32'h12340000);

      // Reset with a store pending: store blocked, WB cleared even under stall.
      @(negedge Clock);
      Reset = 1'b1; Stall = 1'b1;
      drive(1, 0, 2'b00, 0, 1, 0, 5'd7, 32'h0, 32'h55);
      @(posedge Clock); #1;
      check("rst2.wb_rw",   {31'b0, WB_RegWrite}, 32'h0);
      check("rst2.wb_dest", {27'b0, WB_RegDest},  32'h0);
      check("rst2.wb_data", WB_Data,              32'h0);
      @(negedge Clock);
      Reset = 1'b0; Stall = 1'b0;
      drive(0, 1, 2'b00, 0, 1, 1, 5'd2, 32'h0, 32'h0);
      #1;
      check("rst2.mem0", MEM_ReadData, 32'h77);
      @(posedge Clock); #1;
      check("rst2.fresh_rw",   {31'b0, WB_RegWrite}, 32'h1);
      check("rst2.fresh_data", WB_Data,              32'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
